// File: rtl/custom_logic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | custom_logic_pkg : shared states, pixel type and window filter for the TLD |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package custom_logic_pkg;

   localparam int MAX_WIDTH = 1024;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP     = 3'd1,
      READ      = 3'd2,
      WAIT_DATA = 3'd3,
      STORE     = 3'd4,
      UPDATE    = 3'd5,
      WRITE     = 3'd6,
      DONE      = 3'd7
   } state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam logic [1:0] MODE_BAYER  = 2'b00;
   localparam logic [1:0] MODE_BRIGHT = 2'b01;
   localparam logic [1:0] MODE_GRAY   = 2'b10;
   localparam logic [1:0] MODE_PASS   = 2'b11;

   function automatic logic [7:0] sat_add(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   // p00 is the window's top-left site; row_odd/col_odd give its absolute parity,
   // which fixes where the R (even,even) and B (odd,odd) sites fall in the window.
   function automatic pixel_t filter_window(
      input logic [23:0] p00,
      input logic [23:0] p01,
      input logic [23:0] p10,
      input logic [23:0] p11,
      input logic        row_odd,
      input logic        col_odd,
      input logic [1:0]  mode,
      input logic [7:0]  beta
   );
      logic [7:0] r_ch;
      logic [7:0] b_ch;
      logic [7:0] g_a;
      logic [7:0] g_b;
      logic [8:0] g_sum;
      logic [9:0] gray;
      pixel_t     res;

      case ({row_odd, col_odd})
         2'b00: begin r_ch = p00[23:16]; b_ch = p11[7:0]; g_a = p01[15:8]; g_b = p10[15:8]; end
         2'b01: begin r_ch = p01[23:16]; b_ch = p10[7:0]; g_a = p00[15:8]; g_b = p11[15:8]; end
         2'b10: begin r_ch = p10[23:16]; b_ch = p01[7:0]; g_a = p00[15:8]; g_b = p11[15:8]; end
         default: begin r_ch = p11[23:16]; b_ch = p00[7:0]; g_a = p01[15:8]; g_b = p10[15:8]; end
      endcase

      g_sum = {1'b0, g_a} + {1'b0, g_b};
      res   = '0;
      res.r = r_ch;
      res.g = g_sum[8:1];
      res.b = b_ch;
      gray  = {2'b00, res.r} + {1'b0, res.g, 1'b0} + {2'b00, res.b};

      case (mode)
         MODE_BRIGHT: begin
            res.r = sat_add(res.r, beta);
            res.g = sat_add(res.g, beta);
            res.b = sat_add(res.b, beta);
         end
         MODE_GRAY: begin
            res.r = gray[9:2];
            res.g = gray[9:2];
            res.b = gray[9:2];
         end
         MODE_PASS: begin
            res.r = p11[23:16];
            res.g = p11[15:8];
            res.b = p11[7:0];
         end
         default: ;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/custom_logic_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | custom_logic_line_buffer : ping-pong row storage plus output-row buffer    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module custom_logic_line_buffer #(
   parameter int MAX_WIDTH = 1024,
   parameter int AW        = 10
) (
   input  logic          clk,
   input  logic          cur_bank,
   input  logic [AW-1:0] col_idx,
   input  logic          line_wr_en,
   input  logic [23:0]   line_wr_data,
   output logic [23:0]   prev_left,
   output logic [23:0]   prev_right,
   output logic [23:0]   cur_left,
   input  logic          out_wr_en,
   input  logic [AW-1:0] out_wr_idx,
   input  logic [23:0]   out_wr_data,
   input  logic [AW-1:0] out_rd_idx,
   output logic [23:0]   out_rd_data
);

   logic [23:0]   line_mem [2][MAX_WIDTH];
   logic [23:0]   out_mem  [MAX_WIDTH];
   logic [AW-1:0] left_idx;

   // At col 0 left_idx wraps; the window is not used there so the value is don't-care.
   assign left_idx = col_idx - AW'(1);

   always_ff @(posedge clk) begin
      if (line_wr_en)
         line_mem[cur_bank][col_idx] <= line_wr_data;
      if (out_wr_en)
         out_mem[out_wr_idx] <= out_wr_data;
   end

   assign prev_left   = line_mem[~cur_bank][left_idx];
   assign prev_right  = line_mem[~cur_bank][col_idx];
   assign cur_left    = line_mem[cur_bank][left_idx];
   assign out_rd_data = out_mem[out_rd_idx];

endmodule
`default_nettype wire

// File: rtl/custom_logic_tld.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | custom_logic_tld : SDRAM-streaming 2x2 Bayer/brightness/gray image filter |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module custom_logic_tld #(
   parameter int MAX_WIDTH = custom_logic_pkg::MAX_WIDTH
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        startControlRegister,
   input  logic [12:0] imageWidth,
   input  logic [12:0] imageHeight,
   input  logic [25:0] start_addr_sdram,
   input  logic [25:0] finish_addr_sdram,
   input  logic [1:0]  filterMode,
   input  logic [7:0]  betaValue,
   input  logic [31:0] data_sdram,
   input  logic        sdram_datareadvalid,
   output logic        sdram_read_en,
   output logic        sdram_write_en,
   output logic [25:0] address_sdram,
   output logic [31:0] writeData_sdram,
   output logic        finish_flag
);

   import custom_logic_pkg::*;

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   state_t        state;
   state_t        state_next;

   logic [12:0]   cfg_w;
   logic [12:0]   cfg_h;
   logic [1:0]    cfg_mode;
   logic [7:0]    cfg_beta;
   logic [25:0]   cfg_src;
   logic [25:0]   cfg_dst;

   logic [12:0]   row;
   logic [12:0]   col;
   logic [12:0]   wr_cnt;
   logic [25:0]   rd_base;
   logic [25:0]   wr_base;
   logic [23:0]   pix_data;

   logic [12:0]   w_minus1;
   logic          last_col;
   logic          last_wr;
   logic          last_row;
   logic          small_frame;
   logic [25:0]   rd_addr;
   logic [25:0]   wr_addr;

   logic [AW-1:0] col_idx;
   logic [23:0]   prev_left;
   logic [23:0]   prev_right;
   logic [23:0]   cur_left;
   logic          out_wr_en;
   logic [23:0]   out_rd_data;
   pixel_t        win_pix;
   pixel_t        out_pix;
   logic          unused_bits;

   assign w_minus1    = cfg_w - 13'd1;
   assign last_col    = (col == w_minus1);
   assign last_wr     = (wr_cnt == cfg_w - 13'd2);
   assign last_row    = (row == cfg_h - 13'd1);
   assign small_frame = (imageWidth < 13'd2) || (imageHeight < 13'd2);

   // Row bases accumulate per row, so no multiplier sits in the address path.
   assign rd_addr = cfg_src + rd_base + {13'd0, col};
   assign wr_addr = cfg_dst + wr_base + {13'd0, wr_cnt};

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (startControlRegister) state_next = SETUP;
         SETUP:     state_next = small_frame ? DONE : READ;
         READ:      state_next = WAIT_DATA;
         WAIT_DATA: if (sdram_datareadvalid) state_next = STORE;
         STORE:     state_next = UPDATE;
         UPDATE:    state_next = (last_col && (row != 13'd0)) ? WRITE : READ;
         WRITE:     if (last_wr) state_next = last_row ? DONE : READ;
         DONE:      if (!startControlRegister) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cfg_w    <= '0;
         cfg_h    <= '0;
         cfg_mode <= '0;
         cfg_beta <= '0;
         cfg_src  <= '0;
         cfg_dst  <= '0;
         row      <= '0;
         col      <= '0;
         wr_cnt   <= '0;
         rd_base  <= '0;
         wr_base  <= '0;
         pix_data <= '0;
      end else begin
         case (state)
            SETUP: begin
               cfg_w    <= imageWidth;
               cfg_h    <= imageHeight;
               cfg_mode <= filterMode;
               cfg_beta <= betaValue;
               cfg_src  <= start_addr_sdram;
               cfg_dst  <= finish_addr_sdram;
               row      <= '0;
               col      <= '0;
               wr_cnt   <= '0;
               rd_base  <= '0;
               wr_base  <= '0;
            end
            WAIT_DATA: begin
               if (sdram_datareadvalid)
                  pix_data <= data_sdram[23:0];
            end
            UPDATE: begin
               if (!last_col) begin
                  col <= col + 13'd1;
               end else begin
                  col <= '0;
                  if (row == 13'd0) begin
                     row     <= 13'd1;
                     rd_base <= rd_base + {13'd0, cfg_w};
                  end
               end
            end
            WRITE: begin
               if (last_wr) begin
                  wr_cnt  <= '0;
                  wr_base <= wr_base + {13'd0, w_minus1};
                  if (!last_row) begin
                     row     <= row + 13'd1;
                     rd_base <= rd_base + {13'd0, cfg_w};
                  end
               end else begin
                  wr_cnt <= wr_cnt + 13'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign col_idx   = col[AW-1:0];
   assign out_wr_en = (state == STORE) && (row != 13'd0) && (col != 13'd0);
   // Window top-left is (row-1, col-1): its parity is the inverse of the current site's.
   assign win_pix   = filter_window(prev_left, prev_right, cur_left, pix_data,
                                    ~row[0], ~col[0], cfg_mode, cfg_beta);
   assign out_pix   = '{a: 8'h00, r: out_rd_data[23:16], g: out_rd_data[15:8], b: out_rd_data[7:0]};

   custom_logic_line_buffer #(
      .MAX_WIDTH (MAX_WIDTH),
      .AW        (AW)
   ) u_line_buffer (
      .clk          (clk),
      .cur_bank     (row[0]),
      .col_idx      (col_idx),
      .line_wr_en   (state == STORE),
      .line_wr_data (pix_data),
      .prev_left    (prev_left),
      .prev_right   (prev_right),
      .cur_left     (cur_left),
      .out_wr_en    (out_wr_en),
      .out_wr_idx   (col_idx - AW'(1)),
      .out_wr_data  ({win_pix.r, win_pix.g, win_pix.b}),
      .out_rd_idx   (wr_cnt[AW-1:0]),
      .out_rd_data  (out_rd_data)
   );

   always_comb begin
      sdram_read_en   = 1'b0;
      sdram_write_en  = 1'b0;
      address_sdram   = '0;
      writeData_sdram = '0;
      case (state)
         READ: begin
            sdram_read_en = 1'b1;
            address_sdram = rd_addr;
         end
         WAIT_DATA, STORE, UPDATE: begin
            address_sdram = rd_addr;
         end
         WRITE: begin
            sdram_write_en  = 1'b1;
            address_sdram   = wr_addr;
            writeData_sdram = out_pix;
         end
         default: ;
      endcase
   end

   assign finish_flag = (state == DONE);

   assign unused_bits = ^{win_pix.a, data_sdram[31:24]};

endmodule
`default_nettype wire

// File: tb/tb_custom_logic_tld.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_custom_logic_tld : randomized frames against a per-pixel reference model|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_custom_logic_tld;

   localparam int IMG_MAX = 16;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        startControlRegister = 1'b0;
   logic [12:0] imageWidth = '0;
   logic [12:0] imageHeight = '0;
   logic [25:0] start_addr_sdram = '0;
   logic [25:0] finish_addr_sdram = '0;
   logic [1:0]  filterMode = '0;
   logic [7:0]  betaValue = '0;
   logic [31:0] data_sdram = '0;
   logic        sdram_datareadvalid = 1'b0;
   logic        sdram_read_en;
   logic        sdram_write_en;
   logic [25:0] address_sdram;
   logic [31:0] writeData_sdram;
   logic        finish_flag;

   always #5 clk = ~clk;

   custom_logic_tld dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .startControlRegister (startControlRegister),
      .imageWidth           (imageWidth),
      .imageHeight          (imageHeight),
      .start_addr_sdram     (start_addr_sdram),
      .finish_addr_sdram    (finish_addr_sdram),
      .filterMode           (filterMode),
      .betaValue            (betaValue),
      .data_sdram           (data_sdram),
      .sdram_datareadvalid  (sdram_datareadvalid),
      .sdram_read_en        (sdram_read_en),
      .sdram_write_en       (sdram_write_en),
      .address_sdram        (address_sdram),
      .writeData_sdram      (writeData_sdram),
      .finish_flag          (finish_flag)
   );

   typedef struct {
      bit          wr;
      logic [25:0] addr;
      logic [31:0] data;
   } acc_t;

   acc_t        exp_q[$];
   logic [31:0] mem [logic [25:0]];
   logic [23:0] img [IMG_MAX][IMG_MAX];
   int          tests = 0;
   int          fails = 0;
   int          resp_delay = 0;
   bit          exp_next_write = 1'b0;
   logic [31:0] last_wdata = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference pixel from the filter rules applied to the image array directly.
   function automatic logic [23:0] ref_pixel(input int r, input int c, input logic [1:0] mode, input int beta);
      int rv, gv, bv, gsum, y, rr, cc;
      rv = 0; bv = 0; gsum = 0;
      if (mode == 2'b11) return img[r][c];
      for (int dr = 0; dr < 2; dr++) begin
         for (int dc = 0; dc < 2; dc++) begin
            rr = r - 1 + dr;
            cc = c - 1 + dc;
            if ((rr % 2 == 0) && (cc % 2 == 0))      rv = int'(img[rr][cc][23:16]);
            else if ((rr % 2 == 1) && (cc % 2 == 1)) bv = int'(img[rr][cc][7:0]);
            else                                     gsum += int'(img[rr][cc][15:8]);
         end
      end
      gv = gsum / 2;
      if (mode == 2'b01) begin
         rv = (rv + beta > 255) ? 255 : rv + beta;
         gv = (gv + beta > 255) ? 255 : gv + beta;
         bv = (bv + beta > 255) ? 255 : bv + beta;
      end else if (mode == 2'b10) begin
         y  = (rv + 2 * gv + bv) / 4;
         rv = y; gv = y; bv = y;
      end
      return {rv[7:0], gv[7:0], bv[7:0]};
   endfunction

   task automatic build_expected(input int w, input int h, input logic [1:0] mode, input int beta,
                                 input logic [25:0] src, input logic [25:0] dst);
      acc_t e;
      exp_q.delete();
      mem.delete();
      exp_next_write = 1'b0;
      if (w < 2 || h < 2) return;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            e.wr   = 1'b0;
            e.addr = src + 26'(r * w + c);
            e.data = '0;
            exp_q.push_back(e);
            mem[e.addr] = {8'($urandom), img[r][c]};
         end
         if (r >= 1) begin
            for (int k = 0; k < w - 1; k++) begin
               e.wr   = 1'b1;
               e.addr = dst + 26'((r - 1) * (w - 1) + k);
               e.data = {8'h00, ref_pixel(r, k + 1, mode, beta)};
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic apply_cfg(input int w, input int h, input logic [1:0] mode, input logic [7:0] beta,
                            input logic [25:0] src, input logic [25:0] dst, input bit rand_img);
      if (rand_img)
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
               img[r][c] = 24'($urandom);
      build_expected(w, h, mode, int'(beta), src, dst);
      @(negedge clk);
      imageWidth        = 13'(w);
      imageHeight       = 13'(h);
      filterMode        = mode;
      betaValue         = beta;
      start_addr_sdram  = src;
      finish_addr_sdram = dst;
      startControlRegister = 1'b1;
   endtask

   task automatic run_frame(input int w, input int h, input logic [1:0] mode, input logic [7:0] beta,
                            input logic [25:0] src, input logic [25:0] dst,
                            input bit rand_img, input bit timing_chk);
      apply_cfg(w, h, mode, beta, src, dst, rand_img);
      if (timing_chk) begin
         @(negedge clk); check("rd_en_after_1clk", sdram_read_en, 1'b0);
         @(negedge clk); check("rd_en_after_2clk", sdram_read_en, 1'b1);
         check("rd_addr_first", address_sdram, src);
         repeat (3) begin
            @(negedge clk); check("rd_en_gap", sdram_read_en, 1'b0);
         end
         @(negedge clk); check("rd_en_second", sdram_read_en, 1'b1);
         check("rd_addr_second", address_sdram, src + 26'd1);
      end
      for (int i = 0; i < 20000 && finish_flag !== 1'b1; i++) @(negedge clk);
      check("finish_flag_set", finish_flag, 1'b1);
      check("exp_q_drained", exp_q.size(), 0);
      check("done_addr_zero", address_sdram, 26'd0);
      check("done_wdata_zero", writeData_sdram, 32'd0);
      repeat (4) @(negedge clk);
      check("finish_flag_hold", finish_flag, 1'b1);
      startControlRegister = 1'b0;
      @(negedge clk);
      check("finish_flag_clear", finish_flag, 1'b0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_en"}, sdram_read_en, 1'b0);
      check({tag, "_wr_en"}, sdram_write_en, 1'b0);
      check({tag, "_addr"}, address_sdram, 26'd0);
      check({tag, "_wdata"}, writeData_sdram, 32'd0);
      check({tag, "_finish"}, finish_flag, 1'b0);
   endtask

   // SDRAM read responder: strobe after resp_delay extra wait cycles (-1 = random).
   initial begin
      logic [25:0] a;
      int          d;
      forever begin
         @(negedge clk);
         if (sdram_read_en === 1'b1) begin
            a = address_sdram;
            d = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
            repeat (d) begin
               @(negedge clk);
               check("wait_rd_en_low", sdram_read_en, 1'b0);
               check("wait_addr_hold", address_sdram, a);
            end
            @(negedge clk);
            data_sdram          = mem.exists(a) ? mem[a] : 32'd0;
            sdram_datareadvalid = 1'b1;
            @(negedge clk);
            sdram_datareadvalid = 1'b0;
         end
      end
   end

   // Access monitor: every read/write must be the next entry of the expected trace.
   initial begin
      acc_t e;
      forever begin
         @(negedge clk);
         if (exp_next_write) begin
            check("wr_burst_contiguous", sdram_write_en, 1'b1);
            exp_next_write = 1'b0;
         end
         if (sdram_read_en === 1'b1 || sdram_write_en === 1'b1) begin
            check("rw_exclusive", sdram_read_en & sdram_write_en, 1'b0);
            check("access_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check(e.wr ? "wr_kind" : "rd_kind", sdram_write_en, e.wr);
               check(e.wr ? "wr_addr" : "rd_addr", address_sdram, e.addr);
               if (e.wr) begin
                  check("wr_data", writeData_sdram, e.data);
                  last_wdata = writeData_sdram;
               end
               exp_next_write = e.wr && exp_q.size() != 0 && exp_q[0].wr;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w, h;
      logic [25:0] src;

      #1;
      check_idle_outputs("reset");
      repeat (3) @(negedge clk);
      n_rst = 1'b1;

      // Start latency and 4-cycle pixel cadence with an immediate strobe.
      resp_delay = 0;
      run_frame(4, 3, 2'b00, 8'd0, 26'd0, 26'h100, 1'b1, 1'b1);

      // Slow memory: ten extra wait cycles per read.
      resp_delay = 10;
      run_frame(2, 2, 2'b01, 8'd7, 26'h40, 26'h200, 1'b1, 1'b0);

      resp_delay = 0;
      img[0][0] = {8'd200, 8'd0,   8'd0};
      img[0][1] = {8'd0,   8'd100, 8'd0};
      img[1][0] = {8'd0,   8'd50,  8'd0};
      img[1][1] = {8'd0,   8'd0,   8'd30};
      run_frame(2, 2, 2'b00, 8'd0, 26'h10, 26'h300, 1'b0, 1'b0);
      check("bayer_word", last_wdata, 32'h00C84B1E);

      img[0][0] = {8'd250, 8'd0,  8'd0};
      img[0][1] = {8'd0,   8'd10, 8'd0};
      img[1][0] = {8'd0,   8'd10, 8'd0};
      img[1][1] = {8'd0,   8'd0,  8'd100};
      run_frame(2, 2, 2'b01, 8'd20, 26'h20, 26'h400, 1'b0, 1'b0);
      check("bright_saturate", last_wdata, 32'h00FF1E78);

      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            img[r][c] = {8'd60, 8'd60, 8'd60};
      run_frame(2, 2, 2'b10, 8'd0, 26'h30, 26'h500, 1'b0, 1'b0);
      check("gray_word", last_wdata, 32'h003C3C3C);

      // Degenerate sizes finish without touching memory.
      run_frame(1, 4, 2'b00, 8'd0, 26'h50, 26'h600, 1'b1, 1'b0);
      run_frame(5, 1, 2'b00, 8'd0, 26'h50, 26'h600, 1'b1, 1'b0);

      // Reset during the write burst aborts everything immediately.
      apply_cfg(4, 3, 2'b00, 8'd0, 26'h0, 26'h700, 1'b1);
      for (int i = 0; i < 2000 && sdram_write_en !== 1'b1; i++) @(negedge clk);
      check("write_reached", sdram_write_en, 1'b1);
      #2;
      exp_q.delete();
      exp_next_write       = 1'b0;
      startControlRegister = 1'b0;
      n_rst                = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (12) @(negedge clk);
      check_idle_outputs("post_reset");

      // Randomized frames, including source addresses that wrap at 2^26.
      resp_delay = -1;
      for (int t = 0; t < 8; t++) begin
         w   = int'($urandom_range(2, 8));
         h   = int'($urandom_range(2, 6));
         src = ($urandom_range(0, 1) == 1) ? 26'h3FFFFFF - 26'($urandom_range(0, 20)) : 26'($urandom);
         run_frame(w, h, 2'($urandom), 8'($urandom), src, 26'($urandom), 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/custom_logic_tld.md
CUSTOM_LOGIC_TLD -- requirements
Module: custom_logic_tld

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; n_rst  in  1  async active-low reset.
REQ-002 SHALL have input startControlRegister  1  level start request from the host.
REQ-003 SHALL have inputs imageWidth, imageHeight  13 each  input image size in pixels (W, H).
REQ-004 SHALL have inputs start_addr_sdram, finish_addr_sdram  26 each  base word address of the input and output images.
REQ-005 SHALL have inputs filterMode  2  filter select; betaValue  8  brightness offset.
REQ-006 SHALL have inputs data_sdram  32  read data ({A,R,G,B} in bits 31:24/23:16/15:8/7:0); sdram_datareadvalid  1  read-data strobe.
REQ-007 SHALL have outputs sdram_read_en, sdram_write_en  1 each; address_sdram  26; writeData_sdram  32; finish_flag  1.
REQ-008 SHALL have parameter MAX_WIDTH, default 1024, meaning the line-buffer depth; W > MAX_WIDTH is unsupported.

Function
REQ-009 SHALL use states IDLE, SETUP, READ, WAIT_DATA, STORE, UPDATE, WRITE, DONE.
REQ-010 SHALL go IDLE->SETUP when startControlRegister=1, and SETUP->READ on the next edge, so read_en first rises 2 clocks after start is sampled.
REQ-011 SHALL in READ assert sdram_read_en for exactly one cycle with address_sdram = start_addr_sdram + row*W + col (26-bit wrap).
REQ-012 SHALL in WAIT_DATA hold read_en=0 and address unchanged, staying there indefinitely until sdram_datareadvalid=1.
REQ-013 SHALL in STORE capture data_sdram[23:0] into the current-row line buffer at col, and in UPDATE advance col/row, giving 4 cycles per pixel with an immediate strobe.
REQ-014 SHALL during row 0 only fill the line buffer and produce no output.
REQ-015 SHALL for rows r>=1, at each col c>=1, form the 2x2 window P00=(r-1,c-1), P01=(r-1,c), P10=(r,c-1), P11=(r,c) and compute one output pixel into an output-row buffer at index c-1.
REQ-016 SHALL for filterMode 00 apply RGGB Bayer demosaic: R taken from the window site with (row,col) both even, R channel; B from both-odd site, B channel; G = (G of the two mixed-parity sites summed in 9 bits)>>1.
REQ-017 SHALL for filterMode 01 apply mode 00 then add betaValue to each channel, saturating at 255.
REQ-018 SHALL for filterMode 10 output gray=(R+2G+B)>>2 on all three channels of the mode 00 result.
REQ-019 SHALL for filterMode 11 pass P11[23:0] through.
REQ-020 SHALL set output alpha [31:24] = 8'h00.
REQ-021 SHALL after the last read of a row r>=1 enter WRITE and emit W-1 consecutive cycles with sdram_write_en=1, address_sdram = finish_addr_sdram + (r-1)*(W-1) + k, and writeData_sdram = output k, for k=0..W-2.
REQ-022 SHALL never assert read_en and write_en in the same cycle, and SHALL drive address 0 and writeData 0 when neither is asserted in IDLE/DONE.
REQ-023 SHALL after the row H-1 writes enter DONE with finish_flag=1, holding it until startControlRegister=0, then return to IDLE.
REQ-024 SHALL ignore the start input outside IDLE and DONE, and SHALL not restart from DONE while start stays high.
REQ-025 SHALL for W<2 or H<2 go SETUP->DONE directly with no SDRAM access.
REQ-026 SHALL keep row/col counters 13 bits and address arithmetic 26 bits, latching W, H, filterMode, betaValue and the addresses in SETUP.

Reset
REQ-027 SHALL on n_rst=0 immediately go to IDLE with read_en=0, write_en=0, address_sdram=0, writeData_sdram=0, finish_flag=0 and counters=0.
REQ-028 SHALL on reset mid-operation abort the frame, leave buffer contents undefined, and restart only on a new start.

Structure
REQ-029 SHALL place the state enum, the pixel struct {a,r,g,b} and MAX_WIDTH in the shared package custom_logic_pkg.
REQ-030 SHALL place the dual-row line buffer plus output-row buffer, synchronous-write/combinational-read, in one sub-module custom_logic_line_buffer.

Verification
REQ-031 Reset then start=1, W=4, H=3, base 0: read_en pulses at address 0 two clocks after start; strobe after 1 wait cycle -> read_en pulses again 4 clocks later at address 1.
REQ-032 Delay the strobe 10 cycles -> read_en stays 0 and address stays constant until the strobe.
REQ-033 Mode 00, 2x2 window R=200 at (0,0), G=100/50 at mixed sites, B=30 at (1,1) -> written word 0x00C84B1E.
REQ-034 W=4, H=3 -> 6 writes at addresses finish+0..5, each row's 3 writes consecutive and after that row's 4 reads; then finish_flag=1 until start drops.
REQ-035 Mode 01 with betaValue=20 and channel 250 -> 255; mode 10 with R=G=B=60 -> 0x003C3C3C.
REQ-036 Assert n_rst low during WRITE -> all outputs 0 immediately and no further accesses until a new start.
